// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared definitions for the register-file access controller:
//   - FSM state encoding (IDLE=0, SERVE=1, RESP=2, CLEAR=3)
//   - default data width, address width and entry count
package regfile_ctrl_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int NUM_REGS_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      RESP  = 2'd2,
      CLEAR = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter.
// Ports:
//   clk, Reset_n : clock, asynchronous active-low reset
//   req[1:0]     : request vector (bit 0 = master 0)
//   advance      : a grant is being taken this cycle; move the pointer
//   gnt[1:0]     : one-hot grant (combinational from req and pointer)
module rr_arb2
   import regfile_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       Reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // 0 favours master 0, 1 favours master 1
   logic ptr_q;

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

   // After granting master 0 the pointer favours master 1, and vice versa.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr_q <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         ptr_q <= gnt[0];
      end
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Arbitrates two request/ack masters onto the register file's write port
// and read port A, and runs a clear sequence writing zero to every entry.
// Ports:
//   clk, Reset_n              : clock, asynchronous active-low reset
//   mX_req/we/addr/wdata      : master X request (held until mX_ack)
//   mX_ack                    : one-cycle completion pulse
//   mX_rdata                  : read data, valid with mX_ack and held after
//   clr_start                 : one-cycle clear request
//   clr_busy / clr_done       : clear running / one-cycle completion pulse
//   rf_r_addr / rf_r_data     : file read port A (data combinational)
//   rf_w_addr/rf_w_data/rf_write : file write port
//   dbg_state                 : current FSM state (regfile_ctrl_pkg::state_t)
//
// Handshake: a master raises req with we/addr/wdata stable and holds it
// until it sees ack; it must drop req during the ack cycle. Inputs may change
// once the grant is latched. A req still high in the IDLE cycle after the
// ack is a new request.
module regfile_access_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] rf_r_addr,
   input  logic [DATA_W-1:0] rf_r_data,
   output logic [ADDR_W-1:0] rf_w_addr,
   output logic [DATA_W-1:0] rf_w_data,
   output logic              rf_write,
   output logic [1:0]        dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic              pend_q;
   logic              gnt_idx_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              grant_en;
   logic              clear_go;
   logic [1:0]        gnt;

   assign dbg_state = state_q;

   rr_arb2 u_arb (
      .clk     (clk),
      .Reset_n (Reset_n),
      .req     ({m1_req, m0_req}),
      .advance (grant_en),
      .gnt     (gnt)
   );

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and the register-file drive. All rf_* outputs are zero
   // outside SERVE/CLEAR, so reset (state IDLE) forces them to zero at once.
   always_comb begin
      state_d   = state_q;
      grant_en  = 1'b0;
      clear_go  = 1'b0;
      clr_busy  = 1'b0;
      rf_r_addr = '0;
      rf_w_addr = '0;
      rf_w_data = '0;
      rf_write  = 1'b0;
      case (state_q)
         IDLE: begin
            // Clear takes priority over master requests.
            if (pend_q || clr_start) begin
               clear_go = 1'b1;
               state_d  = CLEAR;
            end else if (m0_req || m1_req) begin
               grant_en = 1'b1;
               state_d  = SERVE;
            end
         end
         SERVE: begin
            rf_r_addr = addr_q;
            rf_w_addr = addr_q;
            rf_w_data = wdata_q;
            rf_write  = we_q;
            state_d   = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         CLEAR: begin
            clr_busy  = 1'b1;
            rf_write  = 1'b1;
            rf_w_addr = cnt_q;
            if (cnt_q == LAST_IDX) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         gnt_idx_q <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         clr_done  <= 1'b0;
      end else begin
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         clr_done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clear_go) begin
                  cnt_q  <= '0;
                  pend_q <= 1'b0;
               end else if (grant_en) begin
                  gnt_idx_q <= gnt[1];
                  we_q      <= gnt[1] ? m1_we    : m0_we;
                  addr_q    <= gnt[1] ? m1_addr  : m0_addr;
                  wdata_q   <= gnt[1] ? m1_wdata : m0_wdata;
               end
            end
            SERVE: begin
               if (gnt_idx_q) begin
                  m1_ack <= 1'b1;
                  if (!we_q) m1_rdata <= rf_r_data;
               end else begin
                  m0_ack <= 1'b1;
                  if (!we_q) m0_rdata <= rf_r_data;
               end
               if (clr_start) pend_q <= 1'b1;
            end
            RESP: begin
               if (clr_start) pend_q <= 1'b1;
            end
            CLEAR: begin
               // clr_start is ignored here: no re-arm.
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) clr_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
